// File: rtl/vq_sequencer_if.sv
// Handshake and data bundle between a vector source/quantizer and vq_sequencer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface vq_sequencer_if #(
   parameter int DATA_W = 32
);
   logic              start_i;
   logic              din_valid_i;
   logic [DATA_W-1:0] din_i;
   logic              qvalid_i;
   logic              din_ready_o;
   logic              q_en_o;
   logic [DATA_W-1:0] q_data_o;
   logic [DATA_W-1:0] absmax_o;
   logic              busy_o;
   logic              done_o;
   logic              error_o;

   modport slave (
      input  start_i, din_valid_i, din_i, qvalid_i,
      output din_ready_o, q_en_o, q_data_o, absmax_o, busy_o, done_o, error_o
   );

   modport master (
      output start_i, din_valid_i, din_i, qvalid_i,
      input  din_ready_o, q_en_o, q_data_o, absmax_o, busy_o, done_o, error_o
   );
endinterface

// File: rtl/vq_sequencer.sv
// Buffers one VEC_LEN-element vector while tracking its absmax, streams it to a quantizer,
// then waits for every result. Optional drain watchdog: define VQ_SEQ_TIMEOUT_EN.
module vq_sequencer #(
   parameter int VEC_LEN = 16,
   parameter int DATA_W  = 32
) (
   input logic           clk_i,
   input logic           rst_i,
   vq_sequencer_if.slave bus
);
   localparam int IDX_W = $clog2(VEC_LEN);
   localparam int CNT_W = $clog2(VEC_LEN + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(VEC_LEN - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(VEC_LEN);
   localparam logic [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  load_cnt, issue_cnt;
   logic [CNT_W-1:0]  ret_cnt;
   logic [DATA_W-1:0] absmax_q;
   logic [DATA_W-1:0] din_abs;
   logic [DATA_W-1:0] buffer [VEC_LEN];
   logic              error_q;
   logic              wd_expire;

   logic start_ok, accept, load_last, issue_last, ret_full, count_ret;

   assign start_ok   = (state_q == IDLE) && bus.start_i;
   assign accept     = (state_q == LOAD) && bus.din_valid_i;
   assign load_last  = accept && (load_cnt == LAST_IDX);
   assign issue_last = (state_q == ISSUE) && (issue_cnt == LAST_IDX);
   assign ret_full   = (ret_cnt == FULL_CNT);
   assign count_ret  = ((state_q == ISSUE) || (state_q == DRAIN)) && bus.qvalid_i && !ret_full;

   // Magnitude with saturation: the most negative value has no positive twin.
   always_comb begin
      if (bus.din_i == MIN_VAL)
         din_abs = MAX_POS;
      else if (bus.din_i[DATA_W-1])
         din_abs = ~bus.din_i + DATA_W'(1);
      else
         din_abs = bus.din_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d         = state_q;
      bus.din_ready_o = (state_q == LOAD);
      bus.q_en_o      = (state_q == ISSUE);
      bus.q_data_o    = '0;
      bus.busy_o      = (state_q != IDLE);
      bus.done_o      = (state_q == DONE);
      bus.absmax_o    = absmax_q;
      bus.error_o     = error_q;
      if (state_q == ISSUE)
         bus.q_data_o = buffer[issue_cnt];
      case (state_q)
         IDLE:    if (bus.start_i)           state_d = LOAD;
         LOAD:    if (load_last)             state_d = ISSUE;
         ISSUE:   if (issue_last)            state_d = DRAIN;
         DRAIN:   if (ret_full || wd_expire) state_d = DONE;
         DONE:                               state_d = IDLE;
         default:                            state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         load_cnt  <= '0;
         issue_cnt <= '0;
         ret_cnt   <= '0;
         absmax_q  <= '0;
      end else if (start_ok) begin
         load_cnt  <= '0;
         issue_cnt <= '0;
         ret_cnt   <= '0;
         absmax_q  <= '0;
      end else begin
         if (accept) begin
            load_cnt <= load_last ? '0 : load_cnt + IDX_W'(1);
            if (din_abs > absmax_q)
               absmax_q <= din_abs;
         end
         if (state_q == ISSUE)
            issue_cnt <= issue_last ? '0 : issue_cnt + IDX_W'(1);
         if (count_ret)
            ret_cnt <= ret_cnt + CNT_W'(1);
      end
   end

   // NOTE: the vector buffer has no reset; every entry is written in LOAD before ISSUE reads it.
   always_ff @(posedge clk_i) begin
      if (accept)
         buffer[load_cnt] <= bus.din_i;
   end

`ifdef VQ_SEQ_TIMEOUT_EN
   logic [5:0] wd_cnt;

   // Watchdog fires on the 64th DRAIN cycle unless all results have already returned.
   assign wd_expire = (state_q == DRAIN) && !ret_full && (wd_cnt == 6'd63);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wd_cnt  <= '0;
         error_q <= 1'b0;
      end else begin
         wd_cnt <= (state_q == DRAIN) ? wd_cnt + 6'd1 : 6'd0;
         if (start_ok)
            error_q <= 1'b0;
         else if (wd_expire)
            error_q <= 1'b1;
      end
   end
`else
   assign wd_expire = 1'b0;
   assign error_q   = 1'b0;
`endif

endmodule

// File: tb/tb_vq_sequencer.sv
// Directed bench for vq_sequencer (VEC_LEN=4): a phase-level model checked every cycle,
// plus literal expectations for the canonical vectors, saturation, reset and drain timeout.
module tb_vq_sequencer;
   localparam int VEC_LEN = 4;
   localparam int DATA_W  = 32;
   localparam int P_IDLE = 0, P_LOAD = 1, P_ISSUE = 2, P_DRAIN = 3, P_DONE = 4;

   logic clk = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk = ~clk;

   vq_sequencer_if #(.DATA_W(DATA_W)) bus ();
   vq_sequencer #(.VEC_LEN(VEC_LEN), .DATA_W(DATA_W)) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .bus  (bus)
   );

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

   // Model state
   int          m_phase = P_IDLE;
   logic [31:0] m_buf[$];
   int          m_issued, m_ret, m_wd;
   logic [31:0] m_abs;
   logic        m_err;

   // Quantizer emulation and capture
   logic [2:0]  qv_pipe = '0;
   int          ret_limit = 4;
   int          ret_sent = 0;
   logic [31:0] cap[$];
   int          done_cnt = 0;

   logic [31:0] v1 [4];
   logic [31:0] v2 [4];
   logic [31:0] v3 [4];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   function automatic logic [31:0] sat_abs(logic [31:0] x);
      if (x == 32'h8000_0000) return 32'h7FFF_FFFF;
      if (x[31]) return 32'd0 - x;
      return x;
   endfunction

   task automatic model_step();
      if (rst_i) begin
         m_phase = P_IDLE; m_buf.delete(); m_issued = 0; m_ret = 0; m_wd = 0;
         m_abs = '0; m_err = 1'b0;
         return;
      end
      case (m_phase)
         P_IDLE: if (bus.start_i) begin
            m_phase = P_LOAD; m_buf.delete(); m_issued = 0; m_ret = 0;
            m_abs = '0; m_err = 1'b0;
         end
         P_LOAD: if (bus.din_valid_i) begin
            m_buf.push_back(bus.din_i);
            if (sat_abs(bus.din_i) > m_abs) m_abs = sat_abs(bus.din_i);
            if (m_buf.size() == VEC_LEN) m_phase = P_ISSUE;
         end
         P_ISSUE: begin
            if (bus.qvalid_i && m_ret < VEC_LEN) m_ret++;
            m_issued++;
            if (m_issued == VEC_LEN) begin m_phase = P_DRAIN; m_wd = 0; end
         end
         P_DRAIN: begin
            if (m_ret == VEC_LEN) m_phase = P_DONE;
            else begin
`ifdef VQ_SEQ_TIMEOUT_EN
               m_wd++;
               if (m_wd == 64) begin m_err = 1'b1; m_phase = P_DONE; end
`endif
               if (bus.qvalid_i) m_ret++;
            end
         end
         default: m_phase = P_IDLE;
      endcase
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Per-cycle compare, capture, and quantizer result return about two cycles after each q_en_o.
   initial begin
      bus.qvalid_i = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("din_ready", bus.din_ready_o, m_phase == P_LOAD);
            check("q_en",      bus.q_en_o,      m_phase == P_ISSUE);
            check("q_data",    bus.q_data_o,    (m_phase == P_ISSUE) ? m_buf[m_issued] : 32'd0);
            check("absmax",    bus.absmax_o,    m_abs);
            check("busy",      bus.busy_o,      m_phase != P_IDLE);
            check("done",      bus.done_o,      m_phase == P_DONE);
            check("error",     bus.error_o,     m_err);
         end
         if (bus.q_en_o) cap.push_back(bus.q_data_o);
         if (bus.done_o) done_cnt++;
         qv_pipe = {qv_pipe[1:0], bus.q_en_o};
         if (qv_pipe[2] && ret_sent < ret_limit) begin
            bus.qvalid_i = 1'b1;
            ret_sent++;
         end else begin
            bus.qvalid_i = 1'b0;
         end
      end
   end

   task automatic tick(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick(2);
      rst_i = 1'b0;
      tick(4);
   endtask

   task automatic start_job(int limit);
      ret_limit = limit;
      ret_sent = 0;
      cap.delete();
      done_cnt = 0;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
   endtask

   task automatic load_vec(input logic [31:0] v [4], input bit gap, input bit poke);
      for (int i = 0; i < 4; i++) begin
         if (gap) begin
            bus.start_i = poke;
            tick();
            bus.start_i = 1'b0;
            tick();
         end
         bus.din_valid_i = 1'b1;
         bus.din_i = v[i];
         tick();
         bus.din_valid_i = 1'b0;
         bus.din_i = '0;
      end
   endtask

   // Returns positioned at the negedge inside the DONE cycle; drain_cyc counts DRAIN cycles seen.
   task automatic wait_done(input string name, input int budget, output int drain_cyc);
      bit found = 1'b0;
      drain_cyc = 0;
      for (int i = 0; i < budget && !found; i++) begin
         if (bus.done_o) found = 1'b1;
         else begin
            if (bus.busy_o && !bus.q_en_o && !bus.din_ready_o) drain_cyc++;
            tick();
         end
      end
      check(name, found, 1'b1);
   endtask

   task automatic check_vec(input string name, input logic [31:0] v [4]);
      check({name, "_count"}, cap.size(), 4);
      for (int i = 0; i < 4; i++)
         check({name, "_elem"}, (i < cap.size()) ? cap[i] : 32'hDEAD_BEEF, v[i]);
   endtask

   initial begin
      int d;
      bit hit;
      v1[0] = 32'd5; v1[1] = 32'hFFFF_FFF7; v1[2] = 32'd3; v1[3] = 32'd7;
      v2[0] = 32'h8000_0000; v2[1] = 32'd1; v2[2] = 32'hFFFF_FFFB; v2[3] = 32'd100;
      v3[0] = 32'd11; v3[1] = 32'd22; v3[2] = 32'd33; v3[3] = 32'd44;
      bus.start_i = 1'b0; bus.din_valid_i = 1'b0; bus.din_i = '0;

      do_reset();
      chk_en = 1'b1;
      check("rst_busy", bus.busy_o, 1'b0);
      check("rst_done", bus.done_o, 1'b0);
      check("rst_q_en", bus.q_en_o, 1'b0);
      check("rst_absmax", bus.absmax_o, 32'd0);
      check("rst_error", bus.error_o, 1'b0);

      // Canonical vector; a start in the DONE cycle must be ignored.
      start_job(4);
      load_vec(v1, 1'b0, 1'b0);
      wait_done("job1_done", 60, d);
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      check("job1_start_in_done_ignored", bus.busy_o, 1'b0);
      check("job1_absmax", bus.absmax_o, 32'd9);
      check("job1_done_pulses", done_cnt, 1);
      check_vec("job1_q", v1);
      tick(3);
      check("absmax_held_idle", bus.absmax_o, 32'd9);

      // Most-negative element saturates the magnitude.
      start_job(4);
      load_vec(v2, 1'b0, 1'b0);
      wait_done("job2_done", 60, d);
      tick();
      check("job2_absmax_sat", bus.absmax_o, 32'h7FFF_FFFF);
      check_vec("job2_q", v2);

      // Gapped valid with a stray start during LOAD.
      start_job(4);
      load_vec(v1, 1'b1, 1'b1);
      wait_done("job3_done", 60, d);
      tick();
      check("job3_absmax", bus.absmax_o, 32'd9);
      check("job3_done_pulses", done_cnt, 1);
      check_vec("job3_q", v1);

      // Reset while the second element is being issued.
      start_job(4);
      load_vec(v3, 1'b0, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (bus.q_en_o && bus.q_data_o == 32'd22) hit = 1'b1;
         else tick();
      end
      check("job4_second_issue_seen", hit, 1'b1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("midrst_q_en", bus.q_en_o, 1'b0);
      check("midrst_busy", bus.busy_o, 1'b0);
      check("midrst_absmax", bus.absmax_o, 32'd0);
      tick(4);
      start_job(4);
      load_vec(v1, 1'b0, 1'b0);
      wait_done("job5_done", 60, d);
      tick();
      check("job5_done_pulses", done_cnt, 1);
      check_vec("job5_q", v1);

      // Only three of four results come back.
      start_job(3);
      load_vec(v1, 1'b0, 1'b0);
`ifdef VQ_SEQ_TIMEOUT_EN
      wait_done("timeout_done", 200, d);
      check("timeout_error", bus.error_o, 1'b1);
      check("timeout_drain_cycles", d, 64);
      tick();
      check("error_sticky_idle", bus.error_o, 1'b1);
      start_job(4);
      check("error_cleared_by_start", bus.error_o, 1'b0);
      load_vec(v1, 1'b0, 1'b0);
      wait_done("post_timeout_done", 60, d);
      tick();
`else
      tick(200);
      check("no_timeout_busy", bus.busy_o, 1'b1);
      check("no_timeout_error", bus.error_o, 1'b0);
      do_reset();
      check("no_timeout_reset_busy", bus.busy_o, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish at %0t", $time);
      $fatal(1, "bench timeout");
   end
endmodule
